mc_control: RTL
===============

Name: mc_control

Overview:
Multi-cycle controller: the next generation of the single-cycle Control decoder in the mips top.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Handshakes with instruction and data memories that may stall.
- Emits the same datapath select and enable signals as the single-cycle Control, but per state, with write enables pulsed only in the correct cycle.
- Sits between the mips top and a multi-cycle Datapath holding PC, IR and register state.

Parameters:
EX_CYCLES, 1, cycles spent in EXEC per instruction (1..8); models a slow ALU.
CNT_W, 3, width of the EXEC cycle counter; must satisfy 2^CNT_W >= EX_CYCLES.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
instr  input  32  IR contents from the datapath; valid from DECODE onward.
equal  input  1  rs==rt comparison from the datapath.
imem_ready  input  1  instruction memory has data this cycle.
dmem_ready  input  1  data memory access completes this cycle.
imem_req  output  1  instruction fetch request.
dmem_req  output  1  data access request.
dmem_we  output  1  data write (sw); valid only while dmem_req=1.
IR_WE  output  1  latch instr from instruction memory.
PC_WE  output  1  PC update.
pc_src  output  2  next-PC source: 0 pc+4, 1 branch target, 2 jump target, 3 rs.
GRF_WE  output  1  register file write.
sel_rt_rd_31  output  2  destination select: 0 rt, 1 rd, 2 $31.
sel_alu_dm_pc4  output  2  write-data select: 0 ALU, 1 DM, 2 PC+4.
sel_zero_sign  output  1  immediate extension: 0 zero, 1 sign.
sel_imm32_rt  output  1  ALU B operand: 1 imm32, 0 rt.
ALUOp  output  3  0 add, 1 sub, 2 or, 3 lui.
state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
instr_done  output  1  one-cycle pulse on the final cycle of each instruction.

Behaviour:
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, nop (all-zero word). Decode uses opcode instr[31:26] and funct instr[5:0].
- Reset: on the next edge, state=FETCH and the EXEC counter=0. While reset=1, every enable and request output (imem_req, dmem_req, dmem_we, IR_WE, PC_WE, GRF_WE, instr_done) is forced 0. Select outputs reset to 0.
- Reset mid-operation: any state, including a pending memory request, is abandoned with no write.
- FETCH:
  - imem_req=1, held until imem_ready is high.
  - In the cycle imem_ready=1: IR_WE=1, PC_WE=1, pc_src=0; next state is DECODE.
  - Otherwise stay in FETCH with no writes.
- DECODE (1 cycle):
  - j: PC_WE=1, pc_src=2, instr_done=1, next FETCH.
  - jal: next WB.
  - nop: instr_done=1, next FETCH.
  - All others: next EXEC.
- EXEC:
  - Stays EX_CYCLES cycles, counting 0..EX_CYCLES-1; selects and ALUOp are held constant throughout.
  - On the final cycle:
    - beq: PC_WE=equal, pc_src=1, instr_done=1, next FETCH.
    - jr: PC_WE=1, pc_src=3, instr_done=1, next FETCH.
    - lw/sw: next MEM.
    - R-type/ori/lui: next WB.
- MEM:
  - dmem_req=1; dmem_we=1 for sw.
  - Held until dmem_ready is high; the request and address stay stable while waiting.
  - On ready: sw gives instr_done=1, next FETCH; lw gives next WB.
- WB (1 cycle):
  - GRF_WE=1 and instr_done=1, next FETCH.
  - Selects: R-type uses rd/ALU; ori/lui use rt/ALU; lw uses rt/DM; jal uses $31/PC+4 with PC_WE=1 and pc_src=2.
- Per-instruction encoding: sel_zero_sign=1 for lw/sw/beq, 0 otherwise. sel_imm32_rt=1 for ori/lui/lw/sw.
- Cycle counts with zero memory wait: R-type 3+EX_CYCLES; lw 4+EX_CYCLES; sw 3+EX_CYCLES; beq/jr 2+EX_CYCLES; j 2; jal 3.
- Simultaneous events: reset has priority over ready. imem_ready and dmem_ready are ignored outside FETCH and MEM respectively.
- Unrecognised opcode/funct: behaves as nop (F, D, back to F) unless the trap feature below is enabled.

Optional Feature:
MC_CONTROL_TRAP_EN
- Defined:
  - An unrecognised instruction in DECODE moves to HALT, with no PC_WE and no instr_done.
  - HALT asserts output trap=1 and issues no requests or writes.
  - HALT and trap persist until reset.
- Undefined:
  - The trap port and HALT state do not exist.
  - Unknown instructions execute as nop.

Test Plan:
- reset held 2 cycles, imem_ready=1: state=0, imem_req=1 on the first post-reset cycle. IR_WE and PC_WE are 0 during reset, then 1 the next cycle.
- addu (0x00221821), EX_CYCLES=1, ready always 1: states 0,1,2,4. In WB, GRF_WE=1, sel_rt_rd_31=1, ALUOp=0, instr_done=1; the instruction takes 4 cycles.
- lw (0x8C220004), dmem_ready low 3 cycles: MEM lasts 4 cycles with dmem_req=1 and dmem_we=0 throughout. WB then has sel_alu_dm_pc4=1 and GRF_WE=1.
- beq (0x10220003) with equal=0, then equal=1, EX_CYCLES=3: PC_WE=0 / PC_WE=1 with pc_src=1, only on the third EXEC cycle.
- jal (0x0C000C00): the DECODE→WB path gives GRF_WE=1, sel_rt_rd_31=2, sel_alu_dm_pc4=2, PC_WE=1, pc_src=2. Then reset asserted during a subsequent MEM stall gives no writes and state=0.
- Opcode 0x3F with MC_CONTROL_TRAP_EN: state=5 and trap=1 held 10 cycles, with no requests. Without the macro: returns to FETCH after 2 cycles.

Source files
------------

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS controller stepping each instruction through FETCH/DECODE/EXEC/MEM/WB.
// Latency: 2 (j/nop) to 4+EX_CYCLES (lw) cycles per instruction, plus memory wait cycles.
// Backpressure: FETCH and MEM hold their request stable until imem_ready / dmem_ready.
// Build option: define MC_CONTROL_TRAP_EN to send unknown instructions to a sticky HALT state with trap=1.
module mc_control #(
  parameter int EX_CYCLES = 1,
  parameter int CNT_W     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        equal,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        IR_WE,
  output logic        PC_WE,
  output logic [1:0]  pc_src,
  output logic        GRF_WE,
  output logic [1:0]  sel_rt_rd_31,
  output logic [1:0]  sel_alu_dm_pc4,
  output logic        sel_zero_sign,
  output logic        sel_imm32_rt,
  output logic [2:0]  ALUOp,
  output logic [2:0]  state,
`ifdef MC_CONTROL_TRAP_EN
  output logic        trap,
`endif
  output logic        instr_done
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
`ifdef MC_CONTROL_TRAP_EN
    , S_HALT = 3'd5
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  state_t           state_q, next_state;
  logic [CNT_W-1:0] ex_cnt;
  logic             ex_last;

  logic [5:0] opcode, funct;
  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_nop;
  logic is_exec;
  logic [1:0] dec_pc_src, dec_dst, dec_wd;
  logic [2:0] dec_alu;
  logic       dec_zs, dec_imm;

  // Instruction decode: per-instruction select values, held for the whole instruction.
  always_comb begin
    opcode  = instr[31:26];
    funct   = instr[5:0];
    is_addu = (opcode == OP_RTYPE) && (funct == FN_ADDU);
    is_subu = (opcode == OP_RTYPE) && (funct == FN_SUBU);
    is_jr   = (opcode == OP_RTYPE) && (funct == FN_JR);
    is_ori  = (opcode == OP_ORI);
    is_lui  = (opcode == OP_LUI);
    is_lw   = (opcode == OP_LW);
    is_sw   = (opcode == OP_SW);
    is_beq  = (opcode == OP_BEQ);
    is_j    = (opcode == OP_J);
    is_jal  = (opcode == OP_JAL);
    is_nop  = (instr == 32'd0);
    is_exec = is_addu | is_subu | is_jr | is_ori | is_lui | is_lw | is_sw | is_beq;

    dec_pc_src = is_beq ? 2'd1 : (is_j | is_jal) ? 2'd2 : is_jr ? 2'd3 : 2'd0;
    dec_dst    = (is_addu | is_subu) ? 2'd1 : is_jal ? 2'd2 : 2'd0;
    dec_wd     = is_lw ? 2'd1 : is_jal ? 2'd2 : 2'd0;
    dec_alu    = (is_subu | is_beq) ? 3'd1 : is_ori ? 3'd2 : is_lui ? 3'd3 : 3'd0;
    dec_zs     = is_lw | is_sw | is_beq;
    dec_imm    = is_ori | is_lui | is_lw | is_sw;
  end

  assign ex_last = (ex_cnt == CNT_W'(EX_CYCLES - 1));
  assign state   = state_q;

  // State register; reset abandons whatever is in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= next_state;
  end

  // EXEC cycle counter: counts while in EXEC, cleared on exit so each instruction starts at 0.
  always_ff @(posedge clk) begin
    if (reset)                                ex_cnt <= '0;
    else if ((state_q == S_EXEC) && !ex_last) ex_cnt <= ex_cnt + CNT_W'(1);
    else                                      ex_cnt <= '0;
  end

  // Next-state and per-state outputs; write enables pulse only in the cycle that commits them.
  always_comb begin
    next_state     = state_q;
    imem_req       = 1'b0;
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    IR_WE          = 1'b0;
    PC_WE          = 1'b0;
    GRF_WE         = 1'b0;
    instr_done     = 1'b0;
    pc_src         = 2'd0;
    sel_rt_rd_31   = 2'd0;
    sel_alu_dm_pc4 = 2'd0;
    sel_zero_sign  = 1'b0;
    sel_imm32_rt   = 1'b0;
    ALUOp          = 3'd0;
`ifdef MC_CONTROL_TRAP_EN
    trap           = 1'b0;
`endif

    // IR is only meaningful from DECODE onward, so FETCH keeps selects at zero.
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      pc_src         = dec_pc_src;
      sel_rt_rd_31   = dec_dst;
      sel_alu_dm_pc4 = dec_wd;
      sel_zero_sign  = dec_zs;
      sel_imm32_rt   = dec_imm;
      ALUOp          = dec_alu;
    end

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IR_WE      = 1'b1;
          PC_WE      = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_j) begin
          PC_WE      = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end else if (is_jal) begin
          next_state = S_WB;
        end else if (is_exec) begin
          next_state = S_EXEC;
        end else if (is_nop) begin
          instr_done = 1'b1;
          next_state = S_FETCH;
        end else begin
`ifdef MC_CONTROL_TRAP_EN
          next_state = S_HALT;
`else
          instr_done = 1'b1;
          next_state = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        if (ex_last) begin
          if (is_beq) begin
            PC_WE      = equal;
            instr_done = 1'b1;
            next_state = S_FETCH;
          end else if (is_jr) begin
            PC_WE      = 1'b1;
            instr_done = 1'b1;
            next_state = S_FETCH;
          end else if (is_lw || is_sw) begin
            next_state = S_MEM;
          end else begin
            next_state = S_WB;
          end
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (dmem_ready) begin
          if (is_sw) begin
            instr_done = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end
      end
      S_WB: begin
        GRF_WE     = 1'b1;
        instr_done = 1'b1;
        PC_WE      = is_jal;
        next_state = S_FETCH;
      end
`ifdef MC_CONTROL_TRAP_EN
      S_HALT: begin
        trap       = 1'b1;
        next_state = S_HALT;
      end
`endif
      default: next_state = S_FETCH;
    endcase

    // Reset wins over any ready: nothing is requested or written while it is held.
    if (reset) begin
      imem_req       = 1'b0;
      dmem_req       = 1'b0;
      dmem_we        = 1'b0;
      IR_WE          = 1'b0;
      PC_WE          = 1'b0;
      GRF_WE         = 1'b0;
      instr_done     = 1'b0;
      pc_src         = 2'd0;
      sel_rt_rd_31   = 2'd0;
      sel_alu_dm_pc4 = 2'd0;
      sel_zero_sign  = 1'b0;
      sel_imm32_rt   = 1'b0;
      ALUOp          = 3'd0;
`ifdef MC_CONTROL_TRAP_EN
      trap           = 1'b0;
`endif
    end
  end

endmodule
